// File: rtl/regfile_access_master.sv
// Initiator for a register-file write/read port pair: serialises WRITE, READ,
// read-modify-write and POLL commands and returns one response per command.
module regfile_access_master #(
    parameter int                ADDR_W        = 8,
    parameter int                DATA_W        = 32,
    parameter logic [ADDR_W-1:0] IDLE_RD_ADDR  = 8'hFC,
    parameter int                POLL_INTERVAL = 4,
    parameter int                MAX_POLLS     = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [1:0]            cmd_op,
    input  logic [ADDR_W-1:0]     cmd_addr,
    input  logic [DATA_W-1:0]     cmd_wdata,
    input  logic [DATA_W-1:0]     cmd_mask,
    input  logic [DATA_W/8-1:0]   cmd_be,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_W-1:0]     rsp_data,
    output logic                  rsp_err,
    output logic                  busy,
    output logic                  wr_en,
    output logic [ADDR_W-1:0]     wr_addr,
    output logic [DATA_W-1:0]     wr_data,
    output logic [DATA_W/8-1:0]   wr_be,
    output logic [ADDR_W-1:0]     rd_addr,
    input  logic [DATA_W-1:0]     rd_data
);

    // state     | meaning
    // IDLE      | waiting for a command, cmd_ready high
    // WR        | write strobe on the port for one cycle
    // RD        | rd_addr on target for one cycle (READ, first half of RMW)
    // RMW_WR    | merged value written with all byte enables
    // POLL_RD   | one poll read; compare, time out or wait
    // POLL_WAIT | rd_addr parked for POLL_INTERVAL cycles
    // RESP      | rsp_valid held until rsp_ready
    typedef enum logic [2:0] {
        S_IDLE, S_WR, S_RD, S_RMW_WR, S_POLL_RD, S_POLL_WAIT, S_RESP
    } state_t;

    localparam logic [1:0] OP_WRITE = 2'd0;
    localparam logic [1:0] OP_READ  = 2'd1;
    localparam logic [1:0] OP_RMW   = 2'd2;
    localparam logic [1:0] OP_POLL  = 2'd3;

    localparam int ATT_W  = $clog2(MAX_POLLS + 1);
    localparam int WAIT_W = $clog2(POLL_INTERVAL + 1);
    localparam logic [ATT_W-1:0]  MAX_ATT   = ATT_W'(MAX_POLLS);
    localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(POLL_INTERVAL - 1);

    state_t              state_q, state_d;
    logic [1:0]          op_q, op_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   mask_q, mask_d;
    logic [ATT_W-1:0]    att_q, att_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;

    logic                wr_en_d;
    logic [ADDR_W-1:0]   wr_addr_d;
    logic [DATA_W-1:0]   wr_data_d;
    logic [DATA_W/8-1:0] wr_be_d;
    logic [ADDR_W-1:0]   rd_addr_d;
    logic                rsp_valid_d;
    logic [DATA_W-1:0]   rsp_data_d;
    logic                rsp_err_d;
    logic                poll_match;

    assign cmd_ready  = (state_q == S_IDLE);
    assign busy       = (state_q != S_IDLE);
    assign poll_match = ((rd_data & mask_q) == (wdata_q & mask_q));

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        mask_d      = mask_q;
        att_d       = att_q;
        wait_d      = wait_q;
        wr_en_d     = 1'b0;
        wr_addr_d   = wr_addr;
        wr_data_d   = wr_data;
        wr_be_d     = wr_be;
        rd_addr_d   = rd_addr;
        rsp_valid_d = rsp_valid;
        rsp_data_d  = rsp_data;
        rsp_err_d   = rsp_err;

        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    op_d    = cmd_op;
                    addr_d  = cmd_addr;
                    wdata_d = cmd_wdata;
                    mask_d  = cmd_mask;
                    case (cmd_op)
                        OP_WRITE: begin
                            wr_en_d   = 1'b1;
                            wr_addr_d = cmd_addr;
                            wr_data_d = cmd_wdata;
                            wr_be_d   = cmd_be;
                            state_d   = S_WR;
                        end
                        OP_READ, OP_RMW: begin
                            rd_addr_d = cmd_addr;
                            state_d   = S_RD;
                        end
                        OP_POLL: begin
                            rd_addr_d = cmd_addr;
                            att_d     = '0;
                            state_d   = S_POLL_RD;
                        end
                    endcase
                end
            end
            S_WR: begin
                rsp_data_d  = '0;
                rsp_err_d   = 1'b0;
                rsp_valid_d = 1'b1;
                state_d     = S_RESP;
            end
            S_RD: begin
                rd_addr_d  = IDLE_RD_ADDR;
                rsp_data_d = rd_data;
                rsp_err_d  = 1'b0;
                if (op_q == OP_RMW) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = addr_q;
                    wr_data_d = (rd_data & ~mask_q) | (wdata_q & mask_q);
                    wr_be_d   = '1;
                    state_d   = S_RMW_WR;
                end else begin
                    rsp_valid_d = 1'b1;
                    state_d     = S_RESP;
                end
            end
            S_RMW_WR: begin
                rsp_valid_d = 1'b1;
                state_d     = S_RESP;
            end
            S_POLL_RD: begin
                rd_addr_d  = IDLE_RD_ADDR;
                att_d      = att_q + ATT_W'(1);
                rsp_data_d = rd_data;
                if (poll_match) begin
                    rsp_err_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    state_d     = S_RESP;
                end else if (att_d == MAX_ATT) begin
                    rsp_err_d   = 1'b1;
                    rsp_valid_d = 1'b1;
                    state_d     = S_RESP;
                end else begin
                    wait_d  = WAIT_LOAD;
                    state_d = S_POLL_WAIT;
                end
            end
            S_POLL_WAIT: begin
                if (wait_q == '0) begin
                    rd_addr_d = addr_q;
                    state_d   = S_POLL_RD;
                end else begin
                    wait_d = wait_q - WAIT_W'(1);
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            op_q      <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            mask_q    <= '0;
            att_q     <= '0;
            wait_q    <= '0;
            wr_en     <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            wr_be     <= '0;
            rd_addr   <= IDLE_RD_ADDR;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            mask_q    <= mask_d;
            att_q     <= att_d;
            wait_q    <= wait_d;
            wr_en     <= wr_en_d;
            wr_addr   <= wr_addr_d;
            wr_data   <= wr_data_d;
            wr_be     <= wr_be_d;
            rd_addr   <= rd_addr_d;
            rsp_valid <= rsp_valid_d;
            rsp_data  <= rsp_data_d;
            rsp_err   <= rsp_err_d;
        end
    end

endmodule

// File: tb/tb_regfile_access_master.sv
// Bench for regfile_access_master: emulated register file, reference model of
// each command's effect, and queue-based response/write scoreboards.
module tb_regfile_access_master;

    localparam logic [7:0] IDLE_A = 8'hFC;
    localparam logic [7:0] POLL_A = 8'h40;
    localparam int         PI     = 4;
    localparam int         MP     = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0, cmd_ready;
    logic [1:0]  cmd_op = '0;
    logic [7:0]  cmd_addr = '0;
    logic [31:0] cmd_wdata = '0, cmd_mask = '0;
    logic [3:0]  cmd_be = '0;
    logic        rsp_valid, rsp_ready = 1'b0, rsp_err, busy;
    logic [31:0] rsp_data;
    logic        wr_en;
    logic [7:0]  wr_addr, rd_addr;
    logic [31:0] wr_data, rd_data;
    logic [3:0]  wr_be;

    regfile_access_master dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_mask(cmd_mask),
        .cmd_be(cmd_be), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_err(rsp_err), .busy(busy), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_be(wr_be), .rd_addr(rd_addr), .rd_data(rd_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          lat;
        int          acc;
        bit          poll;
        int          reads;
    } rsp_exp_t;

    typedef struct {
        logic [7:0]  addr;
        logic [31:0] data;
        logic [3:0]  be;
    } wr_exp_t;

    rsp_exp_t rsp_q[$];
    wr_exp_t  wr_q[$];

    int n_checks = 0, n_pass = 0;
    int cyc = 0;
    int hold_req = 0;

    // emulated register file (DUT-side) and reference contents (model-side)
    bit [31:0] mem [256];
    bit [31:0] ref_mem [256];
    int          poll_cnt = 0, poll_base = 0, poll_k = 1;
    logic [31:0] poll_hit = '0, poll_miss = '0;

    task automatic check(input string name, input bit ok, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, exp, $time);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (wr_en)
            for (int b = 0; b < 4; b++)
                if (wr_be[b]) mem[wr_addr][8*b +: 8] <= wr_data[8*b +: 8];
        if (rd_addr == POLL_A) poll_cnt <= poll_cnt + 1;
    end

    always_comb begin
        rd_data = mem[rd_addr];
        if (rd_addr == POLL_A)
            rd_data = ((poll_cnt - poll_base + 1) >= poll_k) ? poll_hit : poll_miss;
    end

    initial begin : rsp_ready_drv
        int held;
        held = 0;
        forever begin
            @(posedge clk);
            #1;
            if (rsp_valid && held < hold_req) begin
                rsp_ready = 1'b0;
                held++;
            end else begin
                rsp_ready = ($urandom_range(0, 3) != 0);
                if (!rsp_valid) held = 0;
            end
        end
    end

    // response, write-port and read-port monitors
    initial begin : monitor
        bit       rv_prev;
        logic [7:0] rd_prev;
        rsp_exp_t e;
        wr_exp_t  w;
        rv_prev = 0;
        rd_prev = IDLE_A;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (rsp_valid) begin
                    if (rsp_q.size() == 0) begin
                        check("rsp_unexpected", 1'b0, rsp_data, 0);
                    end else begin
                        e = rsp_q[0];
                        if (!rv_prev) begin
                            check("rsp_latency", (cyc - e.acc) == e.lat, cyc - e.acc, e.lat);
                            check("rsp_data", rsp_data == e.data, rsp_data, e.data);
                            check("rsp_err", rsp_err == e.err, rsp_err, e.err);
                            if (e.poll)
                                check("poll_reads", (poll_cnt - poll_base) == e.reads,
                                      poll_cnt - poll_base, e.reads);
                        end else begin
                            check("rsp_hold", rsp_data == e.data && rsp_err == e.err,
                                  {rsp_err, rsp_data}, {e.err, e.data});
                        end
                        if (rsp_ready) void'(rsp_q.pop_front());
                    end
                end
                if (wr_en) begin
                    check("wr_no_read", rd_addr == IDLE_A, rd_addr, IDLE_A);
                    if (wr_q.size() == 0) begin
                        check("wr_unexpected", 1'b0, wr_addr, 0);
                    end else begin
                        w = wr_q.pop_front();
                        check("wr_port", wr_addr == w.addr && wr_data == w.data && wr_be == w.be,
                              {wr_be, wr_addr, wr_data}, {w.be, w.addr, w.data});
                    end
                end
                if (rd_addr != IDLE_A)
                    check("rd_single_cycle", rd_prev == IDLE_A, rd_prev, IDLE_A);
            end
            rv_prev = rst_n && rsp_valid;
            rd_prev = rd_addr;
        end
    end

    task automatic issue(input logic [1:0] op, input logic [7:0] a, input logic [31:0] wd,
                         input logic [31:0] m, input logic [3:0] be, input bit wait_done);
        rsp_exp_t e;
        wr_exp_t  w;
        logic [31:0] old, v;
        bit accepted;
        e.err = 0; e.poll = 0; e.reads = 0;
        case (op)
            2'd0: begin
                for (int b = 0; b < 4; b++) if (be[b]) ref_mem[a][8*b +: 8] = wd[8*b +: 8];
                w.addr = a; w.data = wd; w.be = be; wr_q.push_back(w);
                e.data = '0; e.lat = 1;
            end
            2'd1: begin
                e.data = ref_mem[a]; e.lat = 1;
            end
            2'd2: begin
                old = ref_mem[a];
                ref_mem[a] = (old & ~m) | (wd & m);
                w.addr = a; w.data = ref_mem[a]; w.be = 4'hF; wr_q.push_back(w);
                e.data = old; e.lat = 2;
            end
            default: begin
                poll_base = poll_cnt;
                e.poll = 1; e.reads = MP; e.err = 1; e.data = poll_miss;
                for (int k = 1; k <= MP; k++) begin
                    v = (k >= poll_k) ? poll_hit : poll_miss;
                    if ((v & m) == (wd & m)) begin
                        e.reads = k; e.err = 0; e.data = v;
                        break;
                    end
                end
                e.lat = 1 + (e.reads - 1) * (1 + PI);
            end
        endcase
        @(posedge clk);
        #1;
        cmd_op = op; cmd_addr = a; cmd_wdata = wd; cmd_mask = m; cmd_be = be;
        cmd_valid = 1'b1;
        accepted = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (cmd_ready) begin accepted = 1; break; end
        end
        check("cmd_accept", accepted, accepted, 1);
        e.acc = cyc + 1;
        rsp_q.push_back(e);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_wdata = $urandom; cmd_mask = $urandom; cmd_addr = 8'($urandom);
        if (wait_done) begin
            for (int i = 0; i < 400; i++) begin
                if (rsp_q.size() == 0) break;
                @(negedge clk);
            end
            if (rsp_q.size() != 0) begin
                check("rsp_timeout", 1'b0, rsp_q.size(), 0);
                rsp_q.delete();
            end
        end
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: actual running required finished");
        $fatal(1, "bench timed out");
    end

    initial begin : stim
        logic [31:0] m, wd, saved;
        logic [7:0]  a;
        int          op;
        #12;
        check("rst_wr_en", wr_en == 0, wr_en, 0);
        check("rst_rd_addr", rd_addr == IDLE_A, rd_addr, IDLE_A);
        check("rst_rsp", rsp_valid == 0 && rsp_data == 0 && rsp_err == 0, {rsp_valid, rsp_err, rsp_data}, 0);
        check("rst_wr_port", wr_addr == 0 && wr_data == 0 && wr_be == 0, {wr_be, wr_addr, wr_data}, 0);
        check("rst_ready", cmd_ready == 1 && busy == 0, {cmd_ready, busy}, 2'b10);
        @(posedge clk);
        #1 rst_n = 1'b1;

        issue(2'd0, 8'h00, 32'hA5A5_1234, '0, 4'b0011, 1);
        issue(2'd0, 8'h08, 32'h0000_00F0, '0, 4'hF, 1);
        issue(2'd1, 8'h08, '0, '0, '0, 1);
        issue(2'd0, 8'h18, 32'h0000_00FF, '0, 4'hF, 1);
        issue(2'd2, 8'h18, 32'h0000_0A00, 32'h0000_0F0F, '0, 1);
        issue(2'd1, 8'h18, '0, '0, '0, 1);

        poll_hit = 32'h1; poll_miss = 32'h0; poll_k = 3;
        issue(2'd3, POLL_A, 32'h1, 32'h1, '0, 1);
        poll_k = MP + 1;
        hold_req = 5;
        issue(2'd3, POLL_A, 32'h1, 32'h1, '0, 1);
        hold_req = 0;

        // reset while the RMW write strobe is on the port
        issue(2'd0, 8'h30, 32'h1111_2222, '0, 4'hF, 1);
        saved = ref_mem[8'h30];
        issue(2'd2, 8'h30, 32'hFFFF_FFFF, 32'h00FF_00FF, '0, 0);
        @(posedge clk);
        #1;
        check("rmw_wr_state", wr_en == 1, wr_en, 1);
        rst_n = 1'b0;
        #1;
        rsp_q.delete();
        wr_q.delete();
        ref_mem[8'h30] = saved;
        check("arst_wr_en", wr_en == 0 && wr_data == 0 && wr_addr == 0 && wr_be == 0,
              {wr_en, wr_be, wr_addr, wr_data}, 0);
        check("arst_rd_rsp", rd_addr == IDLE_A && rsp_valid == 0 && rsp_err == 0 && rsp_data == 0,
              {rd_addr, rsp_valid, rsp_err, rsp_data}, {IDLE_A, 34'h0});
        check("arst_ready", cmd_ready == 1 && busy == 0, {cmd_ready, busy}, 2'b10);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        issue(2'd1, 8'h30, '0, '0, '0, 1);
        issue(2'd0, 8'h30, 32'hCAFE_F00D, '0, 4'b1010, 1);
        issue(2'd1, 8'h30, '0, '0, '0, 1);

        for (int n = 0; n < 60; n++) begin
            do a = 8'($urandom_range(0, 31) * 4); while (a == POLL_A);
            op = $urandom_range(0, 3);
            wd = $urandom;
            m  = $urandom;
            if (op == 3) begin
                if (m == 0) m = 32'h1;
                poll_hit  = ($urandom & ~m) | (wd & m);
                poll_miss = poll_hit ^ (m & (~m + 32'h1));
                poll_k    = $urandom_range(1, MP + 2);
                issue(2'd3, POLL_A, wd, m, '0, 1);
            end else begin
                issue(2'(op), a, wd, m, 4'($urandom), 1);
            end
        end

        repeat (5) @(posedge clk);
        check("wr_queue_drained", wr_q.size() == 0, wr_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
